// File: rtl/mux_ccff_cfg_select.sv
// rtl/mux_ccff_cfg_select.sv - N:1 routing mux with serial config chain and checked commit
module mux_ccff_cfg_select #(
  parameter int NUM_INPUTS = 8,
  parameter int MEM_ENC    = 0,
  localparam int MEM_W     = (MEM_ENC == 0) ? NUM_INPUTS : $clog2(NUM_INPUTS)
) (
  input  logic                  prog_clk,
  input  logic                  pReset_n,
  input  logic                  ccff_head,
  input  logic                  cfg_shift_en,
  input  logic                  cfg_commit,
  input  logic [NUM_INPUTS-1:0] in,
  output logic                  ccff_tail,
  output logic                  out,
  output logic                  cfg_ack,
  output logic                  cfg_err,
  output logic                  cfg_valid,
  output logic [MEM_W-1:0]      mem_active
);

  localparam int CNT_W = $clog2(MEM_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MEM_W);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_LOADING = 2'd1,
    S_FULL    = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [MEM_W-1:0]   r_shadow;
  logic [MEM_W-1:0]   r_mem;
  logic               r_valid;
  logic               r_err;
  logic               r_ack;
  logic               w_legal;
  logic               w_accept;
  logic               w_shift;
  logic               w_out;

  // A shift is dropped whenever a commit is requested in the same cycle
  assign w_shift  = cfg_shift_en & ~cfg_commit;
  assign w_accept = cfg_commit & (r_state == S_FULL) & w_legal;

  generate
    if (MEM_ENC == 0) begin : g_onehot
      // At most one bit set; all-zero is a legal disconnected mux
      always_comb begin
        w_legal = ((r_shadow & (r_shadow - MEM_W'(1))) == '0);
      end

      // One-hot select: OR of gated inputs, zero until configured
      always_comb begin
        w_out = 1'b0;
        if (r_valid) begin
          w_out = |(in & r_mem);
        end
      end
    end else begin : g_binary
      // Binary select must address an existing input
      always_comb begin
        w_legal = ({1'b0, r_shadow} < (MEM_W + 1)'(NUM_INPUTS));
      end

      // Binary select: pick the addressed input, zero until configured
      always_comb begin
        w_out = 1'b0;
        if (r_valid) begin
          for (int i = 0; i < NUM_INPUTS; i++) begin
            if (r_mem == MEM_W'(i)) begin
              w_out = in[i];
            end
          end
        end
      end
    end
  endgenerate

  // Fill-level FSM next state and bit counter; any commit empties the chain
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (cfg_commit) begin
      w_state_nxt = S_EMPTY;
      w_cnt_nxt   = '0;
    end else if (w_shift) begin
      if (r_cnt != CNT_FULL) begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
      if ((r_cnt + CNT_W'(1)) >= CNT_FULL) begin
        w_state_nxt = S_FULL;
      end else begin
        w_state_nxt = S_LOADING;
      end
    end
  end

  // Fill-level FSM state register
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      r_state <= S_EMPTY;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Shadow chain shifts toward the tail; commit leaves it untouched
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      r_shadow <= '0;
    end else if (w_shift) begin
      if (MEM_W > 1) begin
        r_shadow <= {r_shadow[MEM_W-2:0], ccff_head};
      end else begin
        r_shadow <= ccff_head;
      end
    end
  end

  // Commit outcome: load active memory or raise the sticky error
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      r_mem   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_ack <= w_accept;
      if (w_accept) begin
        r_mem   <= r_shadow;
        r_valid <= 1'b1;
        r_err   <= 1'b0;
      end else if (cfg_commit) begin
        r_err   <= 1'b1;
      end
    end
  end

  assign ccff_tail  = r_shadow[MEM_W-1];
  assign out        = w_out;
  assign cfg_ack    = r_ack;
  assign cfg_err    = r_err;
  assign cfg_valid  = r_valid;
  assign mem_active = r_mem;

endmodule

// File: tb/tb_mux_ccff_cfg_select.sv
// tb/tb_mux_ccff_cfg_select.sv - directed checks for one-hot N=8 and binary N=5 configurations
module tb_mux_ccff_cfg_select;

  logic       prog_clk;
  logic       pReset_n;

  logic       head_a, shift_a, commit_a;
  logic [7:0] in_a;
  logic       tail_a, out_a, ack_a, err_a, valid_a;
  logic [7:0] mem_a;

  logic       head_b, shift_b, commit_b;
  logic [4:0] in_b;
  logic       tail_b, out_b, ack_b, err_b, valid_b;
  logic [2:0] mem_b;

  int n_pass;
  int n_total;

  mux_ccff_cfg_select #(.NUM_INPUTS(8), .MEM_ENC(0)) dut_a (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .ccff_head(head_a),
    .cfg_shift_en(shift_a), .cfg_commit(commit_a), .in(in_a),
    .ccff_tail(tail_a), .out(out_a), .cfg_ack(ack_a), .cfg_err(err_a),
    .cfg_valid(valid_a), .mem_active(mem_a)
  );

  mux_ccff_cfg_select #(.NUM_INPUTS(5), .MEM_ENC(1)) dut_b (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .ccff_head(head_b),
    .cfg_shift_en(shift_b), .cfg_commit(commit_b), .in(in_b),
    .ccff_tail(tail_b), .out(out_b), .cfg_ack(ack_b), .cfg_err(err_b),
    .cfg_valid(valid_b), .mem_active(mem_b)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  task automatic load_a(input logic [7:0] v, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      head_a = v[i];
      shift_a = 1'b1;
      @(posedge prog_clk); #1;
    end
    shift_a = 1'b0;
    head_a = 1'b0;
  endtask

  task automatic commit_dut_a;
    commit_a = 1'b1;
    @(posedge prog_clk); #1;
    commit_a = 1'b0;
  endtask

  task automatic load_b(input logic [2:0] v);
    for (int i = 2; i >= 0; i--) begin
      head_b = v[i];
      shift_b = 1'b1;
      @(posedge prog_clk); #1;
    end
    shift_b = 1'b0;
    head_b = 1'b0;
  endtask

  task automatic commit_dut_b;
    commit_b = 1'b1;
    @(posedge prog_clk); #1;
    commit_b = 1'b0;
  endtask

  task automatic test_reset;
    pReset_n = 1'b0;
    in_a = 8'hFF;
    in_b = 5'h1F;
    #1;
    n_total++;
    if ({tail_a, out_a, ack_a, err_a, valid_a, mem_a} !== 13'd0)
      $display("FAIL reset_a: got %b want 0", {tail_a, out_a, ack_a, err_a, valid_a, mem_a});
    else n_pass++;
    n_total++;
    if ({tail_b, out_b, ack_b, err_b, valid_b, mem_b} !== 8'd0)
      $display("FAIL reset_b: got %b want 0", {tail_b, out_b, ack_b, err_b, valid_b, mem_b});
    else n_pass++;
    @(posedge prog_clk); @(posedge prog_clk); #1;
    pReset_n = 1'b1;
  endtask

  task automatic test_onehot;
    load_a(8'b00000100, 8);
    commit_dut_a;
    n_total++;
    if (mem_a !== 8'b00000100) $display("FAIL onehot_mem: got %b want 00000100", mem_a);
    else n_pass++;
    n_total++;
    if ({ack_a, valid_a, err_a} !== 3'b110) $display("FAIL onehot_ack_valid: got %b want 110", {ack_a, valid_a, err_a});
    else n_pass++;
    @(posedge prog_clk); #1;
    n_total++;
    if (ack_a !== 1'b0) $display("FAIL onehot_ack_pulse: got %b want 0", ack_a);
    else n_pass++;
    in_a = 8'b00000100; #1;
    n_total++;
    if (out_a !== 1'b1) $display("FAIL onehot_out_hi: got %b want 1", out_a);
    else n_pass++;
    in_a = 8'b11111011; #1;
    n_total++;
    if (out_a !== 1'b0) $display("FAIL onehot_out_lo: got %b want 0", out_a);
    else n_pass++;
  endtask

  task automatic test_illegal;
    load_a(8'b00010010, 8);
    commit_dut_a;
    n_total++;
    if ({err_a, ack_a, valid_a, mem_a} !== {3'b101, 8'b00000100})
      $display("FAIL illegal_reject: got err/ack/valid/mem %b want 101_00000100", {err_a, ack_a, valid_a, mem_a});
    else n_pass++;
    load_a(8'b00000001, 8);
    commit_dut_a;
    n_total++;
    if ({err_a, ack_a, mem_a} !== {2'b01, 8'b00000001})
      $display("FAIL illegal_recover: got err/ack/mem %b want 01_00000001", {err_a, ack_a, mem_a});
    else n_pass++;
  endtask

  task automatic test_early_commit;
    load_a(8'b00010000, 5);
    commit_dut_a;
    n_total++;
    if ({err_a, ack_a, mem_a} !== {2'b10, 8'b00000001})
      $display("FAIL early_reject: got err/ack/mem %b want 10_00000001", {err_a, ack_a, mem_a});
    else n_pass++;
    load_a(8'b00000000, 3);
    n_total++;
    if (tail_a !== 1'b1) $display("FAIL early_tail: got %b want 1", tail_a);
    else n_pass++;
    // Shadow now holds a legal 10000000, but only 3 bits since the commit
    commit_dut_a;
    n_total++;
    if ({err_a, ack_a, mem_a} !== {2'b10, 8'b00000001})
      $display("FAIL early_cnt_cleared: got err/ack/mem %b want 10_00000001", {err_a, ack_a, mem_a});
    else n_pass++;
    load_a(8'b00100000, 8);
    commit_dut_a;
    n_total++;
    if ({err_a, ack_a, mem_a} !== {2'b01, 8'b00100000})
      $display("FAIL early_refill: got err/ack/mem %b want 01_00100000", {err_a, ack_a, mem_a});
    else n_pass++;
  endtask

  task automatic test_simultaneous;
    load_a(8'b01000000, 8);
    head_a = 1'b1;
    shift_a = 1'b1;
    commit_a = 1'b1;
    @(posedge prog_clk); #1;
    shift_a = 1'b0;
    commit_a = 1'b0;
    head_a = 1'b0;
    n_total++;
    if ({ack_a, mem_a} !== {1'b1, 8'b01000000})
      $display("FAIL simul_commit: got ack/mem %b want 1_01000000", {ack_a, mem_a});
    else n_pass++;
    n_total++;
    if (tail_a !== 1'b0) $display("FAIL simul_shift_dropped: got tail %b want 0", tail_a);
    else n_pass++;
  endtask

  task automatic test_binary;
    load_b(3'b100);
    commit_dut_b;
    n_total++;
    if ({ack_b, valid_b, err_b, mem_b} !== 6'b110100)
      $display("FAIL bin_commit: got ack/valid/err/mem %b want 110100", {ack_b, valid_b, err_b, mem_b});
    else n_pass++;
    in_b = 5'b10000; #1;
    n_total++;
    if (out_b !== 1'b1) $display("FAIL bin_out_hi: got %b want 1", out_b);
    else n_pass++;
    in_b = 5'b01111; #1;
    n_total++;
    if (out_b !== 1'b0) $display("FAIL bin_out_lo: got %b want 0", out_b);
    else n_pass++;
    load_b(3'b110);
    commit_dut_b;
    in_b = 5'b10000; #1;
    n_total++;
    if ({ack_b, err_b, mem_b, out_b} !== 6'b011001)
      $display("FAIL bin_reject: got ack/err/mem/out %b want 011001", {ack_b, err_b, mem_b, out_b});
    else n_pass++;
  endtask

  task automatic test_async_reset;
    in_a = 8'hFF; #1;
    n_total++;
    if (out_a !== 1'b1) $display("FAIL rst_pre_out: got %b want 1", out_a);
    else n_pass++;
    load_a(8'b00000001, 4);
    #2;
    pReset_n = 1'b0;
    #1;
    n_total++;
    if ({tail_a, out_a, ack_a, err_a, valid_a, mem_a} !== 13'd0)
      $display("FAIL rst_midload: got %b want 0", {tail_a, out_a, ack_a, err_a, valid_a, mem_a});
    else n_pass++;
    @(posedge prog_clk); #1;
    pReset_n = 1'b1;
    load_a(8'b00000010, 8);
    commit_dut_a;
    n_total++;
    if (ack_a !== 1'b1) $display("FAIL rst_ack_before: got %b want 1", ack_a);
    else n_pass++;
    #2;
    pReset_n = 1'b0;
    #1;
    n_total++;
    if ({ack_a, valid_a, out_a, mem_a} !== 11'd0)
      $display("FAIL rst_ackcycle: got ack/valid/out/mem %b want 0", {ack_a, valid_a, out_a, mem_a});
    else n_pass++;
    @(posedge prog_clk); #1;
    pReset_n = 1'b1;
    @(posedge prog_clk); #1;
    n_total++;
    if ({ack_a, valid_a, out_a} !== 3'b000)
      $display("FAIL rst_no_late_ack: got ack/valid/out %b want 000", {ack_a, valid_a, out_a});
    else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    pReset_n = 1'b1;
    head_a = 1'b0; shift_a = 1'b0; commit_a = 1'b0; in_a = 8'h00;
    head_b = 1'b0; shift_b = 1'b0; commit_b = 1'b0; in_b = 5'h00;
    #2;
    test_reset;
    test_onehot;
    test_illegal;
    test_early_commit;
    test_simultaneous;
    test_binary;
    test_async_reset;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
